// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver/transmitter pair.
package uart_pkg;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_EVEN = 2'd1;
  localparam logic [1:0] PARITY_ODD  = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    BRK_WAIT
  } uart_state_e;

  // Frame configuration captured at start detect so mid-frame input changes are ignored.
  typedef struct packed {
    logic [1:0] parity_mode;
    logic       stop_bits;
  } uart_cfg_t;

  // Per-frame status reported alongside data_out.
  typedef struct packed {
    logic parity_error;
    logic framing_error;
    logic brk;
  } uart_flags_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Mode 3 is reserved and behaves as no parity.
  function automatic logic parity_en(input logic [1:0] m);
    return (m == PARITY_EVEN) || (m == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one tick every prescaler_max+1 clocks.
// restart re-phases the counter and captures prescaler_max for the coming frame.
module uart_baud_tick #(
  parameter int PRESCALER_WIDTH = 16
)(
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       restart,
  input  logic [PRESCALER_WIDTH-1:0] prescaler_max,
  output logic                       tick
);

  logic [PRESCALER_WIDTH-1:0] cnt_q;
  logic [PRESCALER_WIDTH-1:0] pmax_q;

  // >= rather than == so a counter can never run past the wrap value.
  assign tick = (cnt_q >= pmax_q);

  // Prescaler counter; wraps on tick, re-phased and reloaded on restart.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      pmax_q <= '0;
    end else if (restart) begin
      cnt_q  <= '0;
      pmax_q <= prescaler_max;
    end else if (tick) begin
      cnt_q  <= '0;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_multi.sv
// Oversampling UART receiver: 3-sample majority per bit, 5..9 data bits,
// runtime parity and stop-bit count, parity/framing/break reporting.
module uart_rx_multi
  import uart_pkg::*;
#(
  parameter int DATA_BITS       = 8,
  parameter int OVERSAMPLE      = 16,
  parameter int PRESCALER_WIDTH = 16,
  parameter int SYNC_STAGES     = 2
)(
  input  logic                       clock,
  input  logic                       reset,
  input  logic [PRESCALER_WIDTH-1:0] prescaler_max,
  input  logic [1:0]                 parity_mode,
  input  logic                       stop_bits,
  input  logic                       signal_in,
  output logic                       we_out,
  output logic [DATA_BITS-1:0]       data_out,
  output logic                       parity_error,
  output logic                       framing_error,
  output logic                       break_out,
  output logic                       busy
);

  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int IW  = $clog2(DATA_BITS);
  localparam int MID = OVERSAMPLE / 2;

  localparam logic [SCW-1:0] SC_S0   = SCW'(MID - 1);
  localparam logic [SCW-1:0] SC_S1   = SCW'(MID);
  localparam logic [SCW-1:0] SC_MP   = SCW'(MID + 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0]  IDX_LAST = IW'(DATA_BITS - 1);

  // Synchroniser and a fill marker so the reset value of the chain is never
  // mistaken for a real idle line.
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   vld_pipe;
  logic                   s;
  logic                   armed_q;

  uart_state_e          state_q, state_d;
  uart_cfg_t            cfg_q;
  logic [SCW-1:0]       sc_q;
  logic [IW-1:0]        idx_q;
  logic [1:0]           smp_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 pbit_q;

  logic        tick;
  logic        mp;
  logic        wrap;
  logic        vote;
  logic        par_en;
  logic        par_err;
  logic        counting;
  logic        start_det;
  logic        frame_end;
  uart_flags_t flags_d;

  assign s        = sync_q[SYNC_STAGES-1];
  assign mp       = tick && (sc_q == SC_MP);
  assign wrap     = tick && (sc_q == SC_LAST);
  assign vote     = maj3(smp_q[0], smp_q[1], s);
  assign par_en   = parity_en(cfg_q.parity_mode);
  assign par_err  = par_en && ((^data_q ^ pbit_q) != (cfg_q.parity_mode == PARITY_ODD));
  assign counting = (state_q != IDLE) && (state_q != BRK_WAIT);

  uart_baud_tick #(
    .PRESCALER_WIDTH(PRESCALER_WIDTH)
  ) u_tick (
    .clock         (clock),
    .reset         (reset),
    .restart       (start_det),
    .prescaler_max (prescaler_max),
    .tick          (tick)
  );

  // Line synchroniser; arming waits for a genuine 1 after reset release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q   <= '1;
      vld_pipe <= '0;
      armed_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], signal_in};
      vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
      armed_q  <= armed_q | (vld_pipe[SYNC_STAGES] & s);
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; frames end at the last stop bit's majority point.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start_det) state_d = START;
      START:    if (mp && vote) state_d = IDLE;
                else if (wrap)  state_d = DATA;
      DATA:     if (wrap && (idx_q == IDX_LAST)) state_d = par_en ? PARITY : STOP1;
      PARITY:   if (wrap) state_d = STOP1;
      STOP1:    if (frame_end) state_d = flags_d.brk ? BRK_WAIT : IDLE;
                else if (wrap) state_d = STOP2;
      STOP2:    if (frame_end) state_d = IDLE;
      BRK_WAIT: if (tick && s) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Decoded per-state outputs: start detect, frame end and the frame's flags.
  always_comb begin
    busy      = (state_q != IDLE);
    start_det = 1'b0;
    frame_end = 1'b0;
    flags_d   = '0;
    case (state_q)
      IDLE: start_det = tick && armed_q && !s;
      STOP1: begin
        if (mp && (!cfg_q.stop_bits || !vote)) begin
          frame_end             = 1'b1;
          flags_d.framing_error = !vote;
          flags_d.brk           = !vote && (data_q == '0) && !(par_en && pbit_q);
        end
      end
      STOP2: begin
        if (mp) begin
          frame_end             = 1'b1;
          flags_d.framing_error = !vote;
        end
      end
      default: ;
    endcase
    flags_d.parity_error = frame_end && par_err;
  end

  // Bit timing, sample capture and data/parity shift.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cfg_q  <= '0;
      sc_q   <= '0;
      idx_q  <= '0;
      smp_q  <= '0;
      data_q <= '0;
      pbit_q <= 1'b0;
    end else begin
      if (start_det) begin
        sc_q              <= SCW'(1);
        cfg_q.parity_mode <= parity_mode;
        cfg_q.stop_bits   <= stop_bits;
        data_q            <= '0;
        pbit_q            <= 1'b0;
      end else if (tick && counting) begin
        sc_q <= (sc_q == SC_LAST) ? '0 : sc_q + 1'b1;
      end
      if (tick && (sc_q == SC_S0)) smp_q[0] <= s;
      if (tick && (sc_q == SC_S1)) smp_q[1] <= s;
      if (state_q == START)             idx_q <= '0;
      else if ((state_q == DATA) && wrap) idx_q <= idx_q + 1'b1;
      if ((state_q == DATA) && mp)   data_q[idx_q] <= vote;
      if ((state_q == PARITY) && mp) pbit_q <= vote;
    end
  end

  // Registered results: one-cycle we_out, data and flags held until next frame end.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      we_out        <= 1'b0;
      data_out      <= '0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      break_out     <= 1'b0;
    end else begin
      we_out <= frame_end;
      if (frame_end) begin
        data_out      <= data_q;
        parity_error  <= flags_d.parity_error;
        framing_error <= flags_d.framing_error;
        break_out     <= flags_d.brk;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_multi.sv
// Directed + randomized bench for uart_rx_multi: a behavioural serial driver
// feeds an 8-bit and a 7-bit receiver; frame-level expectations come from a
// reference function working on whole frames.
module tb_uart_rx_multi;

  localparam int PMAX = 3;
  localparam int BITC = 16 * (PMAX + 1);

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] prescaler_max = 16'(PMAX);
  logic [1:0]  parity_mode = 2'd0;
  logic        stop_bits = 1'b0;
  logic        line8 = 1'b1;
  logic        line7 = 1'b1;

  logic       we8, pe8, fe8, brk8, busy8;
  logic [7:0] data8;
  logic       we7, pe7, fe7, brk7, busy7;
  logic [6:0] data7;

  always #5 clock = ~clock;

  uart_rx_multi #(.DATA_BITS(8)) dut8 (
    .clock(clock), .reset(reset), .prescaler_max(prescaler_max),
    .parity_mode(parity_mode), .stop_bits(stop_bits), .signal_in(line8),
    .we_out(we8), .data_out(data8), .parity_error(pe8),
    .framing_error(fe8), .break_out(brk8), .busy(busy8)
  );

  uart_rx_multi #(.DATA_BITS(7)) dut7 (
    .clock(clock), .reset(reset), .prescaler_max(prescaler_max),
    .parity_mode(parity_mode), .stop_bits(stop_bits), .signal_in(line7),
    .we_out(we7), .data_out(data7), .parity_error(pe7),
    .framing_error(fe7), .break_out(brk7), .busy(busy7)
  );

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       brk;
  } rx_t;

  rx_t q8[$];
  rx_t q7[$];
  int  n_asrt = 0;
  int  n_fail = 0;

  // Record every we_out pulse away from the active edge.
  always @(negedge clock) begin
    if (we8) q8.push_back('{{1'b0, data8}, pe8, fe8, brk8});
    if (we7) q7.push_back('{{2'b00, data7}, pe7, fe7, brk7});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
  endtask

  task automatic drive(input bit sel7, input logic v);
    if (sel7) line7 = v;
    else      line8 = v;
  endtask

  // Frame-level reference: what the receiver must report for a frame.
  function automatic rx_t ref_rx(input logic [8:0] d, input int nb, input int pm,
                                 input bit pbit, input bit s1, input bit two, input bit s2);
    rx_t  r;
    logic [8:0] dm;
    bit   pen;
    dm    = d & ((9'h1 << nb) - 9'h1);
    pen   = (pm == 1) || (pm == 2);
    r.d   = dm;
    r.pe  = pen && ((^dm ^ pbit) != (pm == 2));
    r.fe  = !s1 || (two && !s2);
    r.brk = (dm == 9'h0) && (!pen || !pbit) && !s1;
    return r;
  endfunction

  // Serial driver; optional single-tick spikes at 1-bit centres and
  // configuration scrambling mid-frame (restored afterwards).
  task automatic tx_frame(input bit sel7, input logic [8:0] d, input int nb, input int pm,
                          input bit pbit, input bit s1, input bit two, input bit s2,
                          input bit spikes, input bit scramble);
    logic [1:0]  pm_save;
    logic        st_save;
    logic [15:0] pr_save;
    pm_save = parity_mode;
    st_save = stop_bits;
    pr_save = prescaler_max;
    drive(sel7, 1'b0);
    wait_clk(BITC);
    for (int i = 0; i < nb; i++) begin
      if (scramble && i == 3) begin
        parity_mode   = 2'($urandom);
        stop_bits     = 1'($urandom);
        prescaler_max = 16'($urandom_range(0, 15));
      end
      if (spikes && d[i]) begin
        drive(sel7, 1'b1); wait_clk(BITC/2 - 2);
        drive(sel7, 1'b0); wait_clk(PMAX + 1);
        drive(sel7, 1'b1); wait_clk(BITC/2 - 2);
      end else begin
        drive(sel7, d[i]); wait_clk(BITC);
      end
    end
    if (pm == 1 || pm == 2) begin drive(sel7, pbit); wait_clk(BITC); end
    drive(sel7, s1); wait_clk(BITC);
    if (two) begin drive(sel7, s2); wait_clk(BITC); end
    drive(sel7, 1'b1);
    parity_mode   = pm_save;
    stop_bits     = st_save;
    prescaler_max = pr_save;
  endtask

  task automatic expect_rx(input string tag, input bit sel7, input rx_t e);
    rx_t got;
    int  n;
    wait_clk(2 * BITC);
    @(negedge clock);
    n = sel7 ? q7.size() : q8.size();
    check({tag, " count"}, n, 1);
    if (n > 0) begin
      if (sel7) got = q7.pop_front();
      else      got = q8.pop_front();
      check({tag, " data"}, got.d, e.d);
      check({tag, " parity_error"}, got.pe, e.pe);
      check({tag, " framing_error"}, got.fe, e.fe);
      check({tag, " break"}, got.brk, e.brk);
    end
    if (sel7) q7.delete();
    else      q8.delete();
  endtask

  initial begin
    logic [7:0] lb [3];
    logic [8:0] d;
    int         pm;
    bit         two, pbit;
    lb[0] = 8'h55; lb[1] = 8'hAA; lb[2] = 8'h25;

    // reset state
    wait_clk(5);
    @(negedge clock);
    check("rst we_out", we8, 1'b0);
    check("rst data_out", data8, 8'h00);
    check("rst flags", {pe8, fe8, brk8}, 3'b000);
    check("rst busy", busy8, 1'b0);
    reset = 1'b1;
    wait_clk(10);

    // 8N1 loopback bytes
    foreach (lb[i]) begin
      tx_frame(0, {1'b0, lb[i]}, 8, 0, 0, 1, 0, 1, 0, 0);
      expect_rx($sformatf("8N1 %0h", lb[i]), 0, ref_rx({1'b0, lb[i]}, 8, 0, 0, 1, 0, 1));
    end

    // parity
    parity_mode = 2'd1;
    tx_frame(0, 9'h07, 8, 1, 0, 1, 0, 1, 0, 0);
    expect_rx("8E1 bad", 0, ref_rx(9'h07, 8, 1, 0, 1, 0, 1));
    tx_frame(0, 9'h07, 8, 1, 1, 1, 0, 1, 0, 0);
    expect_rx("8E1 good", 0, ref_rx(9'h07, 8, 1, 1, 1, 0, 1));
    parity_mode = 2'd2;
    tx_frame(0, 9'h07, 8, 2, 0, 1, 0, 1, 0, 0);
    expect_rx("8O1 good", 0, ref_rx(9'h07, 8, 2, 0, 1, 0, 1));

    // framing error then clean frame
    parity_mode = 2'd0;
    tx_frame(0, 9'h3C, 8, 0, 0, 0, 0, 1, 0, 0);
    expect_rx("framing 3C", 0, ref_rx(9'h3C, 8, 0, 0, 0, 0, 1));
    tx_frame(0, 9'h41, 8, 0, 0, 1, 0, 1, 0, 0);
    expect_rx("clean 41", 0, ref_rx(9'h41, 8, 0, 0, 1, 0, 1));

    // break: line low for 20 bit times
    line8 = 1'b0;
    wait_clk(15 * BITC);
    @(negedge clock);
    check("break busy mid", busy8, 1'b1);
    check("break one pulse", q8.size(), 1);
    wait_clk(5 * BITC);
    @(negedge clock);
    check("break busy end", busy8, 1'b1);
    line8 = 1'b1;
    expect_rx("break", 0, ref_rx(9'h00, 8, 0, 0, 0, 0, 1));
    check("break released busy", busy8, 1'b0);
    tx_frame(0, 9'h5A, 8, 0, 0, 1, 0, 1, 0, 0);
    expect_rx("after break 5A", 0, ref_rx(9'h5A, 8, 0, 0, 1, 0, 1));

    // short glitch is a false start
    line8 = 1'b0;
    wait_clk(6 * (PMAX + 1));
    @(negedge clock);
    check("glitch busy", busy8, 1'b1);
    line8 = 1'b1;
    wait_clk(2 * BITC);
    @(negedge clock);
    check("glitch no frame", q8.size(), 0);
    check("glitch idle", busy8, 1'b0);

    // single-tick spikes at data-bit centres
    tx_frame(0, 9'h0F0, 8, 0, 0, 1, 0, 1, 1, 0);
    expect_rx("spikes F0", 0, ref_rx(9'h0F0, 8, 0, 0, 1, 0, 1));

    // reset mid-byte (0x0F, reset during data bit 4 with line held low)
    line8 = 1'b0; wait_clk(BITC);
    line8 = 1'b1; wait_clk(4 * BITC);
    line8 = 1'b0; wait_clk(BITC / 2);
    reset = 1'b0;
    wait_clk(4);
    @(negedge clock);
    check("midrst we_out", we8, 1'b0);
    check("midrst data_out", data8, 8'h00);
    check("midrst flags", {pe8, fe8, brk8}, 3'b000);
    check("midrst busy", busy8, 1'b0);
    reset = 1'b1;
    wait_clk(BITC / 2 + 3 * BITC);
    line8 = 1'b1;
    wait_clk(3 * BITC);
    @(negedge clock);
    check("midrst no frame", q8.size(), 0);
    check("midrst idle", busy8, 1'b0);
    tx_frame(0, 9'h99, 8, 0, 0, 1, 0, 1, 0, 0);
    expect_rx("after rst 99", 0, ref_rx(9'h99, 8, 0, 0, 1, 0, 1));

    // 7O2 on the 7-bit receiver
    parity_mode = 2'd2;
    stop_bits   = 1'b1;
    tx_frame(1, 9'h3F, 7, 2, 1, 1, 1, 1, 0, 0);
    expect_rx("7O2 3F", 1, ref_rx(9'h3F, 7, 2, 1, 1, 1, 1));
    check("7O2 dut8 quiet", q8.size(), 0);

    // randomized frames with mid-frame config scrambling
    for (int k = 0; k < 12; k++) begin
      d    = 9'($urandom_range(0, 255));
      pm   = $urandom_range(0, 3);
      two  = 1'($urandom);
      pbit = (pm == 2) ? ~^d : ^d;
      if ($urandom_range(0, 2) == 0) pbit = ~pbit;
      parity_mode = 2'(pm);
      stop_bits   = two;
      tx_frame(0, d, 8, pm, pbit, 1, two, 1, 0, 1);
      expect_rx($sformatf("rand%0d", k), 0, ref_rx(d, 8, pm, pbit, 1, two, 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
